// File: rtl/riscv_ahb3lite_arb2_pkg.sv
// Shared AHB3-Lite encodings and helpers for the two-master arbiter.
package riscv_ahb3lite_arb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // sel + write + mastlock + trans(2) + size(3) + burst(3) + prot(4); address appended
  localparam int AP_CTRL_W = 15;

  typedef enum logic {
    MST_DCACHE = 1'b0,
    MST_ICACHE = 1'b1
  } master_e;

  function automatic logic is_xfer(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/riscv_ahb3lite_arb2_holdreg.sv
// One-entry address-phase hold register for a master that lost the bus.
module riscv_ahb3lite_holdreg
  import riscv_ahb3lite_arb2_pkg::*;
#(
  parameter int DATA_W = 47
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_valid <= 1'b0;
    else if (i_clear)   r_valid <= 1'b0;
    else if (i_capture) r_valid <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_capture) r_data <= i_data;
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/riscv_ahb3lite_arb2.sv
// Two-master AHB3-Lite arbiter: m0 = dcache (priority), m1 = icache with starvation guard.
module riscv_ahb3lite_arb2
  import riscv_ahb3lite_arb2_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      m0_HSEL,
  input  logic [PHYS_ADDR_SIZE-1:0] m0_HADDR,
  input  logic [XLEN-1:0]           m0_HWDATA,
  output logic [XLEN-1:0]           m0_HRDATA,
  input  logic                      m0_HWRITE,
  input  logic [2:0]                m0_HSIZE,
  input  logic [2:0]                m0_HBURST,
  input  logic [3:0]                m0_HPROT,
  input  logic [1:0]                m0_HTRANS,
  input  logic                      m0_HMASTLOCK,
  output logic                      m0_HREADY,
  output logic                      m0_HRESP,
  input  logic                      m1_HSEL,
  input  logic [PHYS_ADDR_SIZE-1:0] m1_HADDR,
  input  logic [XLEN-1:0]           m1_HWDATA,
  output logic [XLEN-1:0]           m1_HRDATA,
  input  logic                      m1_HWRITE,
  input  logic [2:0]                m1_HSIZE,
  input  logic [2:0]                m1_HBURST,
  input  logic [3:0]                m1_HPROT,
  input  logic [1:0]                m1_HTRANS,
  input  logic                      m1_HMASTLOCK,
  output logic                      m1_HREADY,
  output logic                      m1_HRESP,
  output logic                      HSEL,
  output logic [PHYS_ADDR_SIZE-1:0] HADDR,
  output logic [XLEN-1:0]           HWDATA,
  input  logic [XLEN-1:0]           HRDATA,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic [1:0]                HTRANS,
  output logic                      HMASTLOCK,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  localparam int AP_W  = AP_CTRL_W + PHYS_ADDR_SIZE;
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [AP_W-1:0]  w_live_ap [2];
  logic [AP_W-1:0]  w_hold_ap [2];
  logic [AP_W-1:0]  w_src_ap  [2];
  logic [AP_W-1:0]  w_bus_ap;
  logic [1:0]       w_live_vld, w_hold_vld, w_req, w_capture, w_clear;
  logic [1:0]       w_own_d, w_mst_hready, w_mst_hresp;
  logic             w_arb_ok, w_issue, w_b_sel, w_b_lock;
  logic [1:0]       w_b_trans, w_own_trans;
  master_e          w_grant;

  master_e          r_owner;
  master_e          r_downer;
  logic             r_dvld;
  logic [CNT_W-1:0] r_starve;

  assign w_live_ap[0] = {m0_HSEL, m0_HWRITE, m0_HMASTLOCK, m0_HTRANS, m0_HSIZE,
                         m0_HBURST, m0_HPROT, m0_HADDR};
  assign w_live_ap[1] = {m1_HSEL, m1_HWRITE, m1_HMASTLOCK, m1_HTRANS, m1_HSIZE,
                         m1_HBURST, m1_HPROT, m1_HADDR};

  // Live requests only count while the master itself sees HREADY high.
  assign w_live_vld[0] = !HRESET && m0_HSEL && is_xfer(m0_HTRANS) && w_mst_hready[0];
  assign w_live_vld[1] = !HRESET && m1_HSEL && is_xfer(m1_HTRANS) && w_mst_hready[1];

  for (genvar g = 0; g < 2; g++) begin : g_mst
    localparam master_e L_MST = (g == 0) ? MST_DCACHE : MST_ICACHE;
    logic w_issue_mst;

    riscv_ahb3lite_holdreg #(.DATA_W(AP_W)) u_hold (
      .i_clk     (HCLK),
      .i_rst     (HRESET),
      .i_capture (w_capture[g]),
      .i_clear   (w_clear[g]),
      .i_data    (w_live_ap[g]),
      .o_valid   (w_hold_vld[g]),
      .o_data    (w_hold_ap[g])
    );

    assign w_req[g]        = w_hold_vld[g] || w_live_vld[g];
    assign w_src_ap[g]     = w_hold_vld[g] ? w_hold_ap[g] : w_live_ap[g];
    assign w_issue_mst     = w_issue && HREADY && (w_grant == L_MST);
    assign w_clear[g]      = w_hold_vld[g] && w_issue_mst;
    assign w_capture[g]    = w_live_vld[g] && !w_hold_vld[g] && !w_issue_mst;
    assign w_own_d[g]      = r_dvld && (r_downer == L_MST);
    assign w_mst_hready[g] = HRESET ? 1'b1 : (w_own_d[g] ? HREADY : !w_hold_vld[g]);
    assign w_mst_hresp[g]  = (!HRESET && w_own_d[g] && (HRESP == HRESP_ERROR))
                             ? HRESP_ERROR : HRESP_OKAY;
  end

  // Ownership may only move at a bus-ready boundary outside a burst or locked sequence.
  assign w_own_trans = (r_owner == MST_ICACHE) ? m1_HTRANS : m0_HTRANS;
  assign w_arb_ok    = HREADY && (w_own_trans != HTRANS_SEQ) &&
                       !((r_owner == MST_ICACHE) ? m1_HMASTLOCK : m0_HMASTLOCK);

  always_comb begin
    w_grant = r_owner;
    if (w_arb_ok) begin
      if (w_req[1] && (!w_req[0] || (r_starve >= CNT_W'(STARVE_LIMIT)))) w_grant = MST_ICACHE;
      else if (w_req[0])                                                 w_grant = MST_DCACHE;
    end
  end

  assign w_issue  = !HRESET && ((w_grant == MST_ICACHE) ? w_req[1] : w_req[0]);
  assign w_bus_ap = (w_grant == MST_ICACHE) ? w_src_ap[1] : w_src_ap[0];

  assign {w_b_sel, HWRITE, w_b_lock, w_b_trans, HSIZE, HBURST, HPROT, HADDR} = w_bus_ap;
  assign HSEL      = w_issue && w_b_sel;
  assign HTRANS    = w_issue ? w_b_trans : HTRANS_IDLE;
  assign HMASTLOCK = w_issue && w_b_lock;

  assign HWDATA    = (r_downer == MST_ICACHE) ? m1_HWDATA : m0_HWDATA;
  assign m0_HRDATA = HRDATA;
  assign m1_HRDATA = HRDATA;
  assign m0_HREADY = w_mst_hready[0];
  assign m1_HREADY = w_mst_hready[1];
  assign m0_HRESP  = w_mst_hresp[0];
  assign m1_HRESP  = w_mst_hresp[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_owner  <= MST_ICACHE;
      r_downer <= MST_DCACHE;
      r_dvld   <= 1'b0;
      r_starve <= '0;
    end else if (HREADY) begin
      r_dvld <= w_issue;
      if (w_issue) begin
        r_downer <= w_grant;
        r_owner  <= w_grant;
      end
      if (w_arb_ok && w_issue) begin
        if ((w_grant == MST_ICACHE) || !w_req[1])       r_starve <= '0;
        else if (r_starve < CNT_W'(STARVE_LIMIT))       r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_ahb3lite_arb2.sv
// Directed bench for the two-master AHB3-Lite arbiter.
module tb_riscv_ahb3lite_arb2;
  import riscv_ahb3lite_arb2_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        m0_HSEL, m0_HWRITE, m0_HMASTLOCK, m0_HREADY, m0_HRESP;
  logic [31:0] m0_HADDR, m0_HWDATA, m0_HRDATA;
  logic [2:0]  m0_HSIZE, m0_HBURST;
  logic [3:0]  m0_HPROT;
  logic [1:0]  m0_HTRANS;
  logic        m1_HSEL, m1_HWRITE, m1_HMASTLOCK, m1_HREADY, m1_HRESP;
  logic [31:0] m1_HADDR, m1_HWDATA, m1_HRDATA;
  logic [2:0]  m1_HSIZE, m1_HBURST;
  logic [3:0]  m1_HPROT;
  logic [1:0]  m1_HTRANS;
  logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_ahb3lite_arb2 #(.XLEN(32), .PHYS_ADDR_SIZE(32), .STARVE_LIMIT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_HSEL(m0_HSEL), .m0_HADDR(m0_HADDR), .m0_HWDATA(m0_HWDATA), .m0_HRDATA(m0_HRDATA),
    .m0_HWRITE(m0_HWRITE), .m0_HSIZE(m0_HSIZE), .m0_HBURST(m0_HBURST), .m0_HPROT(m0_HPROT),
    .m0_HTRANS(m0_HTRANS), .m0_HMASTLOCK(m0_HMASTLOCK), .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP),
    .m1_HSEL(m1_HSEL), .m1_HADDR(m1_HADDR), .m1_HWDATA(m1_HWDATA), .m1_HRDATA(m1_HRDATA),
    .m1_HWRITE(m1_HWRITE), .m1_HSIZE(m1_HSIZE), .m1_HBURST(m1_HBURST), .m1_HPROT(m1_HPROT),
    .m1_HTRANS(m1_HTRANS), .m1_HMASTLOCK(m1_HMASTLOCK), .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0_drv(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [2:0] burst);
    m0_HSEL = sel; m0_HTRANS = trans; m0_HADDR = addr; m0_HWRITE = wr; m0_HBURST = burst;
  endtask

  task automatic m1_drv(input logic sel, input logic [1:0] trans, input logic [31:0] addr);
    m1_HSEL = sel; m1_HTRANS = trans; m1_HADDR = addr; m1_HWRITE = 1'b0; m1_HBURST = 3'b000;
  endtask

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = 32'h0;
    m0_HSIZE = 3'b010; m0_HPROT = 4'b0011; m0_HMASTLOCK = 1'b0; m0_HWDATA = 32'h0;
    m1_HSIZE = 3'b010; m1_HPROT = 4'b0010; m1_HMASTLOCK = 1'b0; m1_HWDATA = 32'h0;
    m0_drv(1'b1, HTRANS_NONSEQ, 32'h0000_1000, 1'b1, 3'b000);
    m1_drv(1'b0, HTRANS_IDLE, 32'h0);

    // Reset, with a live m0 request that must not reach the bus
    tick(); tick();
    #2;
    chk("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rst_hsel", 32'(HSEL), 32'd0);
    chk("rst_m0_hready", 32'(m0_HREADY), 32'd1);
    chk("rst_m1_hready", 32'(m1_HREADY), 32'd1);
    chk("rst_m0_hresp", 32'(m0_HRESP), 32'd0);

    // m1 alone reads 0x200
    tick();
    HRESET = 1'b0;
    m0_drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    m1_drv(1'b1, HTRANS_NONSEQ, 32'h0000_0200);
    #2;
    chk("m1_alone_haddr", HADDR, 32'h0000_0200);
    chk("m1_alone_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("m1_alone_hsel", 32'(HSEL), 32'd1);
    chk("m1_alone_m0_hready", 32'(m0_HREADY), 32'd1);
    tick();
    m1_drv(1'b0, HTRANS_IDLE, 32'h0);
    HRDATA = 32'hCAFE_0200;
    #2;
    chk("m1_alone_hrdata", m1_HRDATA, 32'hCAFE_0200);
    chk("m1_alone_dphase_hready", 32'(m1_HREADY), 32'd1);
    chk("m1_alone_bus_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
    HREADY = 1'b0;
    #1;
    chk("m1_stall_hready", 32'(m1_HREADY), 32'd0);
    chk("m0_not_stalled", 32'(m0_HREADY), 32'd1);
    HREADY = 1'b1;

    // m0 write 0x1000 and m1 read 0x204 together
    tick();
    m0_drv(1'b1, HTRANS_NONSEQ, 32'h0000_1000, 1'b1, 3'b000);
    m0_HWDATA = 32'h1111_0000;
    m1_drv(1'b1, HTRANS_NONSEQ, 32'h0000_0204);
    #2;
    chk("contend_haddr", HADDR, 32'h0000_1000);
    chk("contend_hwrite", 32'(HWRITE), 32'd1);
    chk("contend_m1_hready_c0", 32'(m1_HREADY), 32'd1);
    tick();
    m0_drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    m1_drv(1'b0, HTRANS_IDLE, 32'h0);
    #2;
    chk("contend_held_haddr", HADDR, 32'h0000_0204);
    chk("contend_held_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("contend_held_hwrite", 32'(HWRITE), 32'd0);
    chk("contend_m1_hready_held", 32'(m1_HREADY), 32'd0);
    chk("contend_hwdata_m0", HWDATA, 32'h1111_0000);
    tick();
    #2;
    chk("contend_m1_dphase", 32'(m1_HREADY), 32'd1);
    chk("contend_idle", 32'(HTRANS), 32'(HTRANS_IDLE));

    // Starvation: m0 every cycle, m1 pending from the first cycle
    tick();
    m1_drv(1'b1, HTRANS_NONSEQ, 32'h0000_0208);
    for (int i = 0; i < 4; i++) begin
      m0_drv(1'b1, HTRANS_NONSEQ, 32'h0000_2000 + 32'(4 * i), 1'b0, 3'b000);
      #2;
      chk($sformatf("starve_m0_grant%0d", i), HADDR, 32'h0000_2000 + 32'(4 * i));
      if (i > 0) chk($sformatf("starve_m1_wait%0d", i), 32'(m1_HREADY), 32'd0);
      tick();
      m1_drv(1'b0, HTRANS_IDLE, 32'h0);
    end
    m0_drv(1'b1, HTRANS_NONSEQ, 32'h0000_2010, 1'b0, 3'b000);
    #2;
    chk("starve_m1_wins", HADDR, 32'h0000_0208);
    tick();
    m0_drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    #2;
    chk("starve_m0_held_issued", HADDR, 32'h0000_2010);
    chk("starve_m0_held_hready", 32'(m0_HREADY), 32'd0);
    tick();

    // m0 INCR burst with m1 pending mid-burst
    m0_drv(1'b1, HTRANS_NONSEQ, 32'h0000_1000, 1'b0, 3'b001);
    #2;
    chk("burst_b0", HADDR, 32'h0000_1000);
    tick();
    m0_drv(1'b1, HTRANS_SEQ, 32'h0000_1004, 1'b0, 3'b001);
    m1_drv(1'b1, HTRANS_NONSEQ, 32'h0000_020C);
    #2;
    chk("burst_b1", HADDR, 32'h0000_1004);
    chk("burst_b1_seq", 32'(HTRANS), 32'(HTRANS_SEQ));
    tick();
    m1_drv(1'b0, HTRANS_IDLE, 32'h0);
    m0_drv(1'b1, HTRANS_SEQ, 32'h0000_1008, 1'b0, 3'b001);
    #2;
    chk("burst_b2", HADDR, 32'h0000_1008);
    chk("burst_m1_held", 32'(m1_HREADY), 32'd0);
    tick();
    m0_drv(1'b1, HTRANS_SEQ, 32'h0000_100C, 1'b0, 3'b001);
    #2;
    chk("burst_b3", HADDR, 32'h0000_100C);
    tick();
    m0_drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    #2;
    chk("burst_then_m1", HADDR, 32'h0000_020C);
    chk("burst_then_m1_trans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    tick();

    // Two-cycle ERROR on m1 read 0x300 while m0 gets held
    m1_drv(1'b1, HTRANS_NONSEQ, 32'h0000_0300);
    #2;
    chk("err_m1_haddr", HADDR, 32'h0000_0300);
    tick();
    m1_drv(1'b0, HTRANS_IDLE, 32'h0);
    m0_drv(1'b1, HTRANS_NONSEQ, 32'h0000_1010, 1'b1, 3'b000);
    m0_HWDATA = 32'h2222_1010;
    HREADY = 1'b0; HRESP = HRESP_ERROR;
    #2;
    chk("err1_m1_hresp", 32'(m1_HRESP), 32'd1);
    chk("err1_m0_hresp", 32'(m0_HRESP), 32'd0);
    chk("err1_m1_hready", 32'(m1_HREADY), 32'd0);
    chk("err1_m0_hready", 32'(m0_HREADY), 32'd1);
    chk("err1_bus_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
    tick();
    m0_drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    HREADY = 1'b1;
    #2;
    chk("err2_m1_hresp", 32'(m1_HRESP), 32'd1);
    chk("err2_m1_hready", 32'(m1_HREADY), 32'd1);
    chk("err2_m0_hresp", 32'(m0_HRESP), 32'd0);
    chk("err2_m0_held_haddr", HADDR, 32'h0000_1010);
    chk("err2_m0_held_write", 32'(HWRITE), 32'd1);
    chk("err2_m0_hready", 32'(m0_HREADY), 32'd0);
    tick();
    HRESP = HRESP_OKAY;
    #2;
    chk("err_after_m1_hresp", 32'(m1_HRESP), 32'd0);
    chk("err_after_m0_hready", 32'(m0_HREADY), 32'd1);
    chk("err_after_hwdata", HWDATA, 32'h2222_1010);
    tick();

    // Reset while m1 has a held transfer
    m0_drv(1'b1, HTRANS_NONSEQ, 32'h0000_1020, 1'b0, 3'b000);
    m1_drv(1'b1, HTRANS_NONSEQ, 32'h0000_0204);
    #2;
    chk("rsthold_m0_first", HADDR, 32'h0000_1020);
    tick();
    m0_drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    m1_drv(1'b0, HTRANS_IDLE, 32'h0);
    HRESET = 1'b1;
    #2;
    chk("rsthold_during_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rsthold_during_m1_hready", 32'(m1_HREADY), 32'd1);
    tick();
    HRESET = 1'b0;
    #2;
    chk("rsthold_after_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rsthold_after_hsel", 32'(HSEL), 32'd0);
    chk("rsthold_after_m1_hready", 32'(m1_HREADY), 32'd1);
    tick();
    #2;
    chk("rsthold_later_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rsthold_later_m0_hready", 32'(m0_HREADY), 32'd1);
    chk("rsthold_later_m1_hresp", 32'(m1_HRESP), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_ahb3lite_arb2.md
RISCV_AHB3LITE_ARB2 -- requirements
Module: riscv_ahb3lite_arb2

Interface
REQ-001 Parameter XLEN, default 32, data width.
REQ-002 Parameter PHYS_ADDR_SIZE, default XLEN, address width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive m0 grants before a pending m1 SHALL win.
REQ-004 HCLK  input  1  sole clock; all state on rising edge.
REQ-005 HRESET  input  1  reset, synchronous, active-high.
REQ-006 mX_HSEL, mX_HWRITE, mX_HMASTLOCK  input  1 each (X=0,1)  master address-phase controls.
REQ-007 mX_HADDR  input  PHYS_ADDR_SIZE  master address.
REQ-008 mX_HWDATA  input  XLEN  master write data.
REQ-009 mX_HSIZE, mX_HBURST  input  3 each; mX_HPROT  input  4; mX_HTRANS  input  2.
REQ-010 mX_HRDATA  output  XLEN; mX_HREADY, mX_HRESP  output  1 each  returned to master.
REQ-011 HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK  output  widths as mX_  merged bus to slave.
REQ-012 HRDATA  input  XLEN; HREADY, HRESP  input  1  slave response.
REQ-013 m0 SHALL connect to dcache (dat_*), m1 to icache (ins_*).

Function
REQ-014 Valid request: mX_HSEL=1 and mX_HTRANS in {NONSEQ,SEQ}, sampled when mX_HREADY=1.
REQ-015 Each master SHALL have one hold register (valid + address-phase fields) capturing a valid request not issued on the bus that cycle.
REQ-016 Request source per master: hold register when valid, else live inputs.
REQ-017 Bus address phase SHALL be driven from the granted source; with no request, HTRANS=IDLE, HSEL=0.
REQ-018 Arbitration only when bus HREADY=1 and current owner is not mid-burst (live HTRANS≠SEQ, HMASTLOCK=0); otherwise ownership held.
REQ-019 Priority: m0 over m1; starvation counter counts consecutive m0 grants while m1 pending, at STARVE_LIMIT m1 granted and counter cleared; cleared on any m1 grant.
REQ-020 Data-phase owner register SHALL load the granted master when bus HREADY=1 and a transfer is issued; cleared when an IDLE is issued.
REQ-021 HWDATA SHALL mux from live mX_HWDATA of data-phase owner.
REQ-022 mX_HREADY: =HREADY if X owns data phase; =0 if X's hold register valid and not owning data phase; else 1.
REQ-023 HRDATA SHALL broadcast to both mX_HRDATA; mX_HRESP=HRESP for data-phase owner, else 0.
REQ-024 Two-cycle ERROR: owner SHALL see both cycles; a hold register issued into an ERROR cycle SHALL NOT be lost.
REQ-025 Hold register cleared the cycle its transfer is issued with HREADY=1.
REQ-026 Simultaneous m0/m1 valid requests, bus idle: m0 issued, m1 captured; m1 issued next arbitration point.
REQ-027 Zero added latency for the granted uncontended master: address phase passes combinationally.

Reset
REQ-028 On HRESET=1 at a clock edge: hold registers invalid, no data-phase owner, starvation counter 0, owner m1.
REQ-029 During/after reset: HTRANS=IDLE, HSEL=0, mX_HREADY=1, mX_HRESP=0.
REQ-030 Reset mid-transfer SHALL abandon held and in-flight transfers without issuing them.

Structure
REQ-031 HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HRESP (OKAY, ERROR) constants SHALL come from the shared AHB3-Lite package; no local redefinition.
REQ-032 The hold register SHALL be one sub-module, riscv_ahb3lite_holdreg, instantiated per master.

Verification
REQ-033 m1 alone reads 0x200, HREADY=1 -> HADDR=0x200 same cycle, m1_HRDATA valid next cycle, m0_HREADY=1.
REQ-034 m0 write 0x1000 and m1 read 0x204 same cycle -> m0 issued, m1 held with m1_HREADY=0, 0x204 issued next cycle.
REQ-035 m0 requests every cycle, m1 pending -> m1 granted after exactly 4 m0 grants.
REQ-036 m0 INCR burst 0x1000..0x100C with m1 pending -> no m1 grant until the burst's SEQ beats finish.
REQ-037 Slave ERROR on m1 read 0x300 -> m1_HRESP=1 two cycles, m0_HRESP=0, held m0 transfer issued afterwards.
REQ-038 HRESET asserted with m1 held -> next cycle HTRANS=IDLE, m1_HREADY=1, 0x204 never issued.
